fp_register_status: RTL
=======================

Name: fp_register_status

Overview:
- Read-side companion of the FP register file in the Tomasulo datapath.
- Holds the per-register producer tag table (Qi) for R1..R7.
- At issue, returns each source operand as either a ready value or a producer tag, then renames the destination.
- On a CDB broadcast, clears the matching Qi entry and drives the register-file write port (dataIn/dataAddress/writeEnable).

Parameters:
- DATA_W, 16, operand / register data width
- TAG_W, 3, reservation-station tag width; tag 0 = "no producer / value ready"

Ports:
- clock  in  1  system clock, all state changes on rising edge
- reset_n  in  1  synchronous reset, active low
- R1..R7  in  DATA_W each  current register-file contents
- issue_valid  in  1  issue request this cycle
- issue_src1  in  3  source register 1 address (0 = unused)
- issue_src2  in  3  source register 2 address (0 = unused)
- issue_dest  in  3  destination register address (0 = no destination)
- issue_tag  in  TAG_W  tag of the RS receiving the instruction, nonzero when issue_dest != 0
- cdb_valid  in  1  common data bus broadcast valid
- cdb_tag  in  TAG_W  producing RS tag
- cdb_data  in  DATA_W  broadcast result
- op_valid  out  1  operand bundle valid (registered)
- op1_value, op2_value  out  DATA_W  operand value, meaningful when the matching tag = 0
- op1_tag, op2_tag  out  TAG_W  producer tag; 0 = value ready
- rf_dataIn  out  DATA_W  register-file write data (combinational)
- rf_dataAddress  out  3  register-file write address (combinational)
- rf_writeEnable  out  1  register-file write enable (combinational)
- reg_busy  out  8  bit i = (Qi[i] != 0); bit 0 constant 0

Behaviour:
- Reset:
  - Synchronous, active low: when reset_n = 0 at a rising edge, all Qi = 0, op_valid = 0, op1/op2 value and tag = 0.
  - rf_writeEnable is forced 0 while reset_n = 0.
- Address 0 is not a register:
  - As a source it reads value 0, tag 0.
  - As a destination it causes no rename.
- Operand lookup (per source, evaluated on pre-edge state):
  - Qi[src] = 0 → value = R[src], tag = 0.
  - Qi[src] != 0 and cdb_valid and cdb_tag == Qi[src] → forward: value = cdb_data, tag = 0.
  - Otherwise → value = 0, tag = Qi[src].
- Operand output latency:
  - Lookup result is registered into op*_value/op*_tag on the edge where issue_valid = 1; op_valid = 1 for exactly that next cycle.
  - With no issue, op_valid = 0 and operand registers hold.
- Rename: on an issue edge with issue_dest != 0, Qi[issue_dest] <= issue_tag.
- Source equal to destination: sources read the pre-rename Qi. Example: issue R2 = R2 + R3 returns R2's old status.
- CDB write-back:
  - When cdb_valid and some r has Qi[r] == cdb_tag (tag != 0): rf_writeEnable = 1, rf_dataAddress = r, rf_dataIn = cdb_data, all in the same cycle. Qi[r] <= 0 on that edge.
  - The register file latches on the same edge, so the next cycle sees Qi = 0 and the updated R value consistently.
- No match, or cdb_tag = 0: rf_writeEnable = 0, rf_dataAddress = 0, rf_dataIn = 0.
- Simultaneous issue rename and CDB hitting the same register:
  - Rename wins: Qi <= issue_tag.
  - rf_writeEnable = 0 for that register; the stale result is dropped.
  - Sources in the same issue still receive the forwarded cdb_data.
- Tag uniqueness: the RS allocator guarantees at most one register maps to a tag. If more than one matches, the lowest index is written and all matching entries clear; the bench flags this as a protocol error.
- Issue is never stalled. There is no ready output; the upstream issue logic owns RS availability.
- Reset mid-operation: all pending tags are discarded; no write is produced for a CDB arriving during reset.

Test Plan:
- Reset → reg_busy = 0, op_valid = 0, rf_writeEnable = 0; issue src1 = 1, src2 = 4 with R1 = 1, R4 = 2 → next cycle op1 = 1/0, op2 = 2/0, op_valid = 1.
- Rename then read: issue dest = 3, tag = 5; next issue src1 = 3 → op1_tag = 5, op1_value = 0; reg_busy[3] = 1.
- Write-back: with Qi[3] = 5, drive cdb_valid, tag = 5, data = 16'h00A0 → same cycle rf_writeEnable = 1, addr = 3, dataIn = 00A0; next cycle reg_busy[3] = 0.
- Forwarding: with Qi[3] = 5, issue src2 = 3 in the same cycle as CDB tag 5, data = 7 → op2 = 7/0.
- Rename vs CDB: with Qi[6] = 2, issue dest = 6, tag = 4 plus CDB tag = 2 in the same cycle → rf_writeEnable = 0, Qi[6] = 4.
- Reset mid-operation: with Qi[1] = 3, Qi[5] = 6, assert reset_n = 0 with cdb_valid, tag = 3 → rf_writeEnable = 0; after release reg_busy = 0.

Source files
------------

// File: rtl/fp_register_status.sv
// FP register status table for the Tomasulo datapath: tracks the producer tag of R1..R7,
// resolves issue-time source operands and steers CDB results into the register file.
module fp_register_status #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] R1,
  input  logic [DATA_W-1:0] R2,
  input  logic [DATA_W-1:0] R3,
  input  logic [DATA_W-1:0] R4,
  input  logic [DATA_W-1:0] R5,
  input  logic [DATA_W-1:0] R6,
  input  logic [DATA_W-1:0] R7,
  input  logic              issue_valid,
  input  logic [2:0]        issue_src1,
  input  logic [2:0]        issue_src2,
  input  logic [2:0]        issue_dest,
  input  logic [TAG_W-1:0]  issue_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              op_valid,
  output logic [DATA_W-1:0] op1_value,
  output logic [TAG_W-1:0]  op1_tag,
  output logic [DATA_W-1:0] op2_value,
  output logic [TAG_W-1:0]  op2_tag,
  output logic [DATA_W-1:0] rf_dataIn,
  output logic [2:0]        rf_dataAddress,
  output logic              rf_writeEnable,
  output logic [7:0]        reg_busy
);

  logic [TAG_W-1:0]  qi_q [1:7];
  logic [TAG_W-1:0]  qi_d [1:7];
  logic [TAG_W-1:0]  qi_all_s [0:7];
  logic [DATA_W-1:0] rf_s [0:7];
  logic [7:0]        hit_s;
  logic              wb_found_s;
  logic [2:0]        wb_idx_s;
  logic              rename_s;
  logic              op_valid_q;
  logic [DATA_W-1:0] op1_value_q, op2_value_q;
  logic [TAG_W-1:0]  op1_tag_q, op2_tag_q;
  logic [DATA_W+TAG_W-1:0] look1_s, look2_s;

  // Resolve one source: ready value, same-cycle CDB forward, or pending producer tag.
  function automatic logic [DATA_W+TAG_W-1:0] lookup(
    input logic [TAG_W-1:0]  q,
    input logic [DATA_W-1:0] v,
    input logic              fwd_v,
    input logic [TAG_W-1:0]  fwd_tag,
    input logic [DATA_W-1:0] fwd_data
  );
    if (q == {TAG_W{1'b0}}) begin
      return {v, {TAG_W{1'b0}}};
    end else if (fwd_v && (fwd_tag == q)) begin
      return {fwd_data, {TAG_W{1'b0}}};
    end else begin
      return {{DATA_W{1'b0}}, q};
    end
  endfunction

  assign rf_s[0] = {DATA_W{1'b0}};
  assign rf_s[1] = R1;
  assign rf_s[2] = R2;
  assign rf_s[3] = R3;
  assign rf_s[4] = R4;
  assign rf_s[5] = R5;
  assign rf_s[6] = R6;
  assign rf_s[7] = R7;

  assign rename_s = issue_valid && (issue_dest != 3'd0);

  // Address 0 behaves as an always-ready zero register; also derive per-register CDB hits.
  always_comb begin
    qi_all_s[0] = {TAG_W{1'b0}};
    hit_s       = 8'd0;
    reg_busy    = 8'd0;
    for (int r = 1; r <= 7; r++) begin
      qi_all_s[r] = qi_q[r];
      hit_s[r]    = cdb_valid && (cdb_tag != {TAG_W{1'b0}}) && (qi_q[r] == cdb_tag);
      reg_busy[r] = (qi_q[r] != {TAG_W{1'b0}});
    end
  end

  // Lowest matching register receives the CDB write (tags are normally unique).
  always_comb begin
    wb_found_s = 1'b0;
    wb_idx_s   = 3'd0;
    for (int r = 7; r >= 1; r--) begin
      if (hit_s[r]) begin
        wb_found_s = 1'b1;
        wb_idx_s   = 3'(r);
      end else begin
        wb_found_s = wb_found_s;
      end
    end
  end

  // A rename landing on the written register makes the broadcast result stale.
  always_comb begin
    rf_writeEnable = reset_n && wb_found_s && !(rename_s && (issue_dest == wb_idx_s));
    rf_dataAddress = rf_writeEnable ? wb_idx_s : 3'd0;
    rf_dataIn      = rf_writeEnable ? cdb_data : {DATA_W{1'b0}};
  end

  // Next tag table: rename has priority over the CDB clear.
  always_comb begin
    for (int r = 1; r <= 7; r++) begin
      qi_d[r] = (rename_s && (issue_dest == 3'(r))) ? issue_tag :
                (hit_s[r] ? {TAG_W{1'b0}} : qi_q[r]);
    end
  end

  assign look1_s = lookup(qi_all_s[issue_src1], rf_s[issue_src1], cdb_valid, cdb_tag, cdb_data);
  assign look2_s = lookup(qi_all_s[issue_src2], rf_s[issue_src2], cdb_valid, cdb_tag, cdb_data);

  // State and operand registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int r = 1; r <= 7; r++) begin
        qi_q[r] <= {TAG_W{1'b0}};
      end
      op_valid_q  <= 1'b0;
      op1_value_q <= {DATA_W{1'b0}};
      op1_tag_q   <= {TAG_W{1'b0}};
      op2_value_q <= {DATA_W{1'b0}};
      op2_tag_q   <= {TAG_W{1'b0}};
    end else begin
      for (int r = 1; r <= 7; r++) begin
        qi_q[r] <= qi_d[r];
      end
      op_valid_q <= issue_valid;
      if (issue_valid) begin
        {op1_value_q, op1_tag_q} <= look1_s;
        {op2_value_q, op2_tag_q} <= look2_s;
      end
    end
  end

  assign op_valid  = op_valid_q;
  assign op1_value = op1_value_q;
  assign op1_tag   = op1_tag_q;
  assign op2_value = op2_value_q;
  assign op2_tag   = op2_tag_q;

endmodule
